// File: rtl/ttt_move_entry_if.sv
// Core-facing move channel of ttt_move_entry: move strobe, mark and cursor out;
// core error and game-over status back in.
interface ttt_move_entry_if;
  logic       move_valid;
  logic [1:0] xoroin;
  logic [1:0] rowin;
  logic [1:0] colin;
  logic       core_err;
  logic       game_over;

  modport master (
    output move_valid, xoroin, rowin, colin,
    input  core_err, game_over
  );

  modport slave (
    input  move_valid, xoroin, rowin, colin,
    output core_err, game_over
  );
endinterface

// File: rtl/ttt_move_entry.sv
// Pushbutton move entry for the tictactoe core: debounce, 3x3 cursor, turn tracking.
// Optional held-button auto-repeat for row/col when TTT_AUTOREPEAT_EN is defined.
module ttt_move_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_row,
  input  logic              btn_col,
  input  logic              btn_commit,
  input  logic              ai_mode,
  ttt_move_entry_if.master  core,
  output logic              turn,
  output logic              bad_move,
  output logic [3:0]        move_count
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCheck, StLocked} state_e;

  // Button index: 0 = row, 1 = col, 2 = commit.
  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     db_q, db_d;
  logic [2:0]     press;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  assign btn_raw = {btn_commit, btn_col, btn_row};

  // Counter runs only while the synced value disagrees with the debounced level,
  // so any return of the synced value clears it.
  always_comb begin
    db_d  = db_q;
    press = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i]  = sync2_q[i];
          press[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  logic row_press, col_press, commit_press;

`ifdef TTT_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);

  logic [RepW-1:0] rep_q [2];
  logic [RepW-1:0] rep_d [2];
  logic [1:0]      rep_press;

  always_comb begin
    rep_press = '0;
    for (int i = 0; i < 2; i++) begin
      rep_d[i] = '0;
      if (db_q[i]) begin
        if (rep_q[i] == RepW'(REPEAT_CYCLES - 1)) begin
          rep_press[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + RepW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) rep_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) rep_q[i] <= rep_d[i];
    end
  end

  assign row_press = press[0] | rep_press[0];
  assign col_press = press[1] | rep_press[1];
`else
  assign row_press = press[0];
  assign col_press = press[1];
`endif

  assign commit_press = press[2];

  state_e     state_q, state_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic       turn_q, turn_d, bad_q, bad_d;
  logic [3:0] count_q, count_d;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    turn_d  = turn_q;
    bad_d   = bad_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (core.game_over) begin
          state_d = StLocked;
        end else if (commit_press) begin
          state_d = StIssue;
        end else begin
          if (row_press) row_d = inc3(row_q);
          if (col_press) col_d = inc3(col_q);
        end
      end
      StIssue: state_d = StCheck;
      StCheck: begin
        state_d = StIdle;
        if (core.core_err) begin
          bad_d = 1'b1;
        end else begin
          bad_d   = 1'b0;
          count_d = (count_q == 4'd9) ? 4'd9 : count_q + 4'd1;
          turn_d  = ai_mode ? 1'b0 : ~turn_q;
        end
      end
      StLocked: begin
        if (!core.game_over) begin
          state_d = StIdle;
          turn_d  = 1'b0;
          count_d = 4'd0;
          bad_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      turn_q  <= 1'b0;
      bad_q   <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      turn_q  <= turn_d;
      bad_q   <= bad_d;
      count_q <= count_d;
    end
  end

  // Strobe decoded straight from state so reset drops it asynchronously.
  assign core.move_valid = (state_q == StIssue);
  assign core.xoroin     = core.move_valid ? (turn_q ? 2'b10 : 2'b01) : 2'b00;
  assign core.rowin      = row_q;
  assign core.colin      = col_q;
  assign turn            = turn_q;
  assign bad_move        = bad_q;
  assign move_count      = count_q;

endmodule

// File: tb/tb_ttt_move_entry.sv
// Directed bench for ttt_move_entry: window-based reference model compared every cycle,
// plus literal checks of cursor, move strobe, turn and reset behaviour.
module tb_ttt_move_entry;

  localparam int DB = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_row, btn_col, btn_commit, ai_mode;
  logic       turn, bad_move;
  logic [3:0] move_count;

  ttt_move_entry_if core_if ();

  ttt_move_entry dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_row    (btn_row),
    .btn_col    (btn_col),
    .btn_commit (btn_commit),
    .ai_mode    (ai_mode),
    .core       (core_if),
    .turn       (turn),
    .bad_move   (bad_move),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button level flips once the last DB synchronized samples
  // (raw samples from two or more edges ago) all disagree with it.
  logic [DB+1:0] hist [3];
  logic [2:0]    mlvl;
  logic [2:0]    ev;
  logic [2:0]    raw_now;
  int            mphase;  // 0 idle, 1 move on bus, 2 awaiting verdict, 3 game over
  int            mrow, mcol, mcnt;
  logic          mturn, mbad;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      mlvl = '0; mphase = 0; mrow = 0; mcol = 0; mcnt = 0; mturn = 0; mbad = 0;
    end else begin
      raw_now = {btn_commit, btn_col, btn_row};
      ev = '0;
      for (int i = 0; i < 3; i++) begin
        if (hist[i][DB:1] == {DB{~mlvl[i]}}) begin
          mlvl[i] = ~mlvl[i];
          ev[i]   = mlvl[i];
        end
        hist[i] = {hist[i][DB:0], raw_now[i]};
      end
      case (mphase)
        0: begin
          if (core_if.game_over) mphase = 3;
          else if (ev[2]) mphase = 1;
          else begin
            if (ev[0]) mrow = (mrow + 1) % 3;
            if (ev[1]) mcol = (mcol + 1) % 3;
          end
        end
        1: mphase = 2;
        2: begin
          mphase = 0;
          if (core_if.core_err) mbad = 1;
          else begin
            mbad  = 0;
            mcnt  = (mcnt < 9) ? mcnt + 1 : 9;
            mturn = ai_mode ? 1'b0 : ~mturn;
          end
        end
        default: if (!core_if.game_over) begin
          mphase = 0; mturn = 0; mcnt = 0; mbad = 0;
        end
      endcase
    end
  end

  logic [12:0] exp_vec, act_vec;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    exp_vec = {mphase == 1, (mphase == 1) ? (mturn ? 2'b10 : 2'b01) : 2'b00,
               2'(mrow), 2'(mcol), mturn, mbad, 4'(mcnt)};
    act_vec = {core_if.move_valid, core_if.xoroin, core_if.rowin, core_if.colin,
               turn, bad_move, move_count};
    check($sformatf("cycle_outputs@%0d", cyc), 32'(act_vec), 32'(exp_vec));
  end

  // Move strobe monitor used by the literal checks.
  int         mv_pulses = 0;
  logic [1:0] last_xo, last_row, last_col;

  always @(negedge clk) begin
    if (core_if.move_valid) begin
      mv_pulses++;
      last_xo  = core_if.xoroin;
      last_row = core_if.rowin;
      last_col = core_if.colin;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // b: 0 row, 1 col, 2 commit
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_row = v;
      1: btn_col = v;
      default: btn_commit = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cycles(20);
    set_btn(b, 1'b0);
    cycles(24);
  endtask

  int pulses_before;

  initial begin
    reset_n = 1'b0;
    btn_row = 0; btn_col = 0; btn_commit = 0; ai_mode = 0;
    core_if.core_err = 0; core_if.game_over = 0;
    #1;
    check("reset_move_valid", 32'(core_if.move_valid), 32'd0);
    check("reset_counts", 32'({turn, bad_move, move_count}), 32'd0);
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Short glitch is filtered.
    btn_col = 1; cycles(5); btn_col = 0; cycles(24);
    check("short_col_ignored", 32'(core_if.colin), 32'd0);

    // Raw edge to cursor change latency.
    btn_col = 1; cycles(17);
    check("col_before_18", 32'(core_if.colin), 32'd0);
    cycles(1);
    check("col_at_18", 32'(core_if.colin), 32'd1);
    cycles(2); btn_col = 0; cycles(24);
    check("col_once", 32'(core_if.colin), 32'd1);

    // Cursor (2,1), accepted move.
    press(0); press(0);
    check("row_is_2", 32'(core_if.rowin), 32'd2);
    pulses_before = mv_pulses;
    press(2);
    check("move_one_pulse", 32'(mv_pulses - pulses_before), 32'd1);
    check("move_fields", 32'({last_xo, last_row, last_col}), 32'({2'b01, 2'd2, 2'd1}));
    check("after_accept", 32'({turn, bad_move, move_count}), 32'({1'b1, 1'b0, 4'd1}));

    // Rejected move, then an accepted one clears bad_move.
    core_if.core_err = 1;
    press(2);
    check("after_reject", 32'({turn, bad_move, move_count}), 32'({1'b1, 1'b1, 4'd1}));
    check("reject_mark_o", 32'(last_xo), 32'(2'b10));
    core_if.core_err = 0;
    press(2);
    check("after_reaccept", 32'({turn, bad_move, move_count}), 32'({1'b0, 1'b0, 4'd2}));
    press(2);
    check("third_move", 32'({turn, move_count}), 32'({1'b1, 4'd3}));

    // Game over locks entry; release resets turn and count.
    core_if.game_over = 1;
    cycles(2);
    pulses_before = mv_pulses;
    press(2);
    check("locked_no_move", 32'(mv_pulses - pulses_before), 32'd0);
    core_if.game_over = 0;
    cycles(2);
    check("unlock_clear", 32'({turn, bad_move, move_count}), 32'd0);
    check("unlock_cursor_kept", 32'({core_if.rowin, core_if.colin}), 32'({2'd2, 2'd1}));

    // AI mode: human is always X.
    ai_mode = 1;
    press(2);
    check("ai_move1_x", 32'({last_xo, turn}), 32'({2'b01, 1'b0}));
    press(2);
    check("ai_move2_x", 32'({last_xo, turn, move_count}), 32'({2'b01, 1'b0, 4'd2}));
    ai_mode = 0;

    // Row wraps 2 -> 0.
    press(0);
    check("row_wrap", 32'(core_if.rowin), 32'd0);

    // Reset while the move is on the bus.
    press(1);
    btn_commit = 1;
    cycles(18);
    check("issue_seen", 32'(core_if.move_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_issue_bus",
          32'({core_if.move_valid, core_if.xoroin, core_if.rowin, core_if.colin}), 32'd0);
    check("rst_mid_issue_counts", 32'({turn, bad_move, move_count}), 32'd0);
    btn_commit = 0;
    cycles(3);
    reset_n = 1'b1;
    cycles(30);
    check("post_reset_idle", 32'(core_if.move_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
